booth_mult_r4: RTL and testbench
================================

Name: booth_mult_r4

Overview:
Parametrised radix-4 (modified) Booth sequential multiplier. It is the successor to the 16-bit radix-2 Booth datapath/controller pair.
- Separate operand ports replace the shared data bus.
- Supports signed and unsigned operation, selected per transaction.
- Retires two multiplier bits per cycle.
- Sits as a multi-cycle arithmetic unit behind a start/done handshake.

Parameters:
WIDTH, 16, operand width in bits; must be even and >= 4 (elaborate-time check, fatal on violation).
ITER, WIDTH/2+1, derived localparam; number of Booth iterations. Not overridable.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-low (asserted when 0)
start  input  1  request; sampled only in IDLE
signed_mode  input  1  1 = two's-complement operands, 0 = unsigned; captured with operands
multiplicand  input  WIDTH  operand M; captured on accepted start
multiplier  input  WIDTH  operand Q; captured on accepted start
busy  output  1  high in CALC and DONE
done  output  1  one-cycle pulse; product valid
product  output  2*WIDTH  result; held until the next accepted start

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; busy=0; done=0; product=0; all internal registers cleared.
  - Reset mid-operation aborts the operation with no done pulse.
- FSM states:
  - IDLE: start=1 is accepted at the edge. Capture operands extended to WIDTH+2 bits: sign-extended if signed_mode=1, zero-extended otherwise. Clear accumulator A (WIDTH+3 bits). Clear Booth bit q(-1). Load iteration counter with ITER. Go to CALC.
  - CALC: each cycle, examine triplet {Q[1],Q[0],q(-1)}:
    - 000 or 111 -> +0
    - 001 or 010 -> +M
    - 011 -> +2M
    - 100 -> -2M
    - 101 or 110 -> -M
  - CALC step update: A plus or minus the term in WIDTH+3-bit two's complement. Then arithmetic-right-shift {A,Q,q(-1)} by 2. Decrement the counter.
  - CALC exit: when the counter reaches 0 after the update, latch product = low 2*WIDTH bits of {A,Q} and go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Latency:
  - The accept edge is E0.
  - The last iteration occurs at edge E_ITER.
  - done is high for the cycle between E_ITER and E_ITER+1 (WIDTH=16: done high 9 cycles after the accept edge).
  - Throughput: one multiply per ITER+2 cycles.
- start in CALC or DONE is ignored; operand and mode changes while busy have no effect.
- start held high continuously re-triggers from IDLE, giving back-to-back operations separated by one IDLE cycle.
- The product is exact in both modes. There is no overflow condition.
  - Signed most-negative x most-negative (WIDTH=16) = 0x40000000.
  - Unsigned max x max = (2^WIDTH-1)^2.
- Zero operands take the full ITER cycles unless the optional feature is enabled.

Optional Feature:
Macro BOOTH_ZERO_SKIP_EN.
- Defined: on an accepted start where either captured operand is zero, the FSM goes IDLE -> DONE directly. product=0 is latched at the accept edge, and done is high the cycle after E0. busy is high for that one cycle only.
- Undefined: no zero detection logic; all operations take ITER CALC cycles.

Test Plan:
- WIDTH=16, signed_mode=1, M=0xFFFD (-3), Q=0x0005 -> done 9 cycles after accept, product=0xFFFFFFF1, busy high for 10 cycles.
- WIDTH=16, signed_mode=0, M=Q=0xFFFF -> product=0xFFFE0001; the same operands with signed_mode=1 -> product=0x00000001.
- WIDTH=16, signed_mode=1, M=Q=0x8000 -> product=0x40000000. Then, with no start, hold inputs changing for 20 cycles -> product stays 0x40000000 and done stays 0.
- Start with 7x6 unsigned. Pulse start with 2x2 at cycle 3 while busy -> ignored; single done, product=0x0000002A.
- Start 0x1234x0x0010. Drive rst=0 asynchronously mid-CALC (cycle 4) -> product=0, busy=0, done never pulses. After release, a new 3x3 -> product=9.
- With BOOTH_ZERO_SKIP_EN: M=0, Q=0x1234 -> done the cycle after accept, product=0. Without the macro -> done after 9 cycles, product=0. Also run a WIDTH=8 random sweep of 1000 signed and unsigned pairs against a behavioural multiply.

Source files
------------

// File: rtl/booth_mult_r4.sv
// Radix-4 (modified) Booth sequential multiplier with start/done handshake, signed or unsigned per operation.
// Optional macro BOOTH_ZERO_SKIP_EN: a zero operand bypasses CALC and finishes in one cycle.
module booth_mult_r4 #(
   parameter int WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 signed_mode,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int ITER = WIDTH / 2 + 1;
   localparam int AW   = WIDTH + 3;
   localparam int QW   = WIDTH + 2;
   localparam int CW   = $clog2(ITER + 1);

   generate
      if (WIDTH < 4 || (WIDTH % 2) != 0) begin : g_bad_width
         $fatal(1, "booth_mult_r4: WIDTH must be even and >= 4");
      end
   endgenerate

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   state_t          state;
   state_t          state_next;
   logic [AW-1:0]   acc;
   logic [AW-1:0]   acc_sum;
   logic [AW-1:0]   acc_sh;
   logic [QW-1:0]   mcand;
   logic [QW-1:0]   mult;
   logic [QW-1:0]   mult_sh;
   logic [QW-1:0]   mcand_in;
   logic [QW-1:0]   mult_in;
   logic            qm1;
   logic [CW-1:0]   cnt;
   logic [AW-1:0]   m_ext;
   logic [AW-1:0]   m_dbl;
   logic [2:0]      trip;
   logic            last;

   assign mcand_in = {{2{signed_mode & multiplicand[WIDTH-1]}}, multiplicand};
   assign mult_in  = {{2{signed_mode & multiplier[WIDTH-1]}}, multiplier};
   assign m_ext    = {mcand[QW-1], mcand};
   assign m_dbl    = {mcand, 1'b0};
   assign trip     = {mult[1:0], qm1};
   assign last     = (cnt == CW'(1));

   always_comb begin
      acc_sum = acc;
      unique case (trip)
         3'b001, 3'b010: acc_sum = acc + m_ext;
         3'b011:         acc_sum = acc + m_dbl;
         3'b100:         acc_sum = acc - m_dbl;
         3'b101, 3'b110: acc_sum = acc - m_ext;
         default:        acc_sum = acc;
      endcase
   end

   // {A,Q,q(-1)} shifted right arithmetically by two after the add
   assign acc_sh  = {{2{acc_sum[AW-1]}}, acc_sum[AW-1:2]};
   assign mult_sh = {acc_sum[1:0], mult[QW-1:2]};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (start) begin
`ifdef BOOTH_ZERO_SKIP_EN
               if (multiplicand == '0 || multiplier == '0) state_next = DONE;
               else                                        state_next = CALC;
`else
               state_next = CALC;
`endif
            end
         end
         CALC:    if (last) state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      busy = (state != IDLE);
      done = (state == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         acc     <= '0;
         mcand   <= '0;
         mult    <= '0;
         qm1     <= 1'b0;
         cnt     <= '0;
         product <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  acc   <= '0;
                  mcand <= mcand_in;
                  mult  <= mult_in;
                  qm1   <= 1'b0;
                  cnt   <= CW'(ITER);
`ifdef BOOTH_ZERO_SKIP_EN
                  if (multiplicand == '0 || multiplier == '0) product <= '0;
`endif
               end
            end
            CALC: begin
               acc <= acc_sh;
               mult <= mult_sh;
               qm1 <= mult[1];
               cnt <= cnt - CW'(1);
               if (last) product <= {acc_sh[WIDTH-3:0], mult_sh};
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_booth_mult_r4.sv
// Self-checking bench for booth_mult_r4: directed WIDTH=16 vectors, handshake corner cases, WIDTH=8 random sweep.
module tb_booth_mult_r4;

   typedef struct {
      logic        sm;
      logic [15:0] m;
      logic [15:0] q;
      logic [31:0] exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        start = 1'b0;
   logic        signed_mode = 1'b0;
   logic [15:0] multiplicand = '0;
   logic [15:0] multiplier = '0;
   logic        busy;
   logic        done;
   logic [31:0] product;

   logic        start8 = 1'b0;
   logic        sm8 = 1'b0;
   logic [7:0]  m8 = '0;
   logic [7:0]  q8 = '0;
   logic        busy8;
   logic        done8;
   logic [15:0] prod8;

   int checks = 0;
   int passes = 0;

   booth_mult_r4 #(.WIDTH(16)) dut (
      .clk(clk), .rst(rst), .start(start), .signed_mode(signed_mode),
      .multiplicand(multiplicand), .multiplier(multiplier),
      .busy(busy), .done(done), .product(product)
   );

   booth_mult_r4 #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
      .multiplicand(m8), .multiplier(q8),
      .busy(busy8), .done(done8), .product(prod8)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
   endtask

   // One transaction: lat counts edges after the accept edge until done is seen
   task automatic apply_stimulus(input logic sm_i, input logic [15:0] m_i, input logic [15:0] q_i,
                                 output int lat, output int busy_cnt, output logic [31:0] prod);
      @(negedge clk);
      signed_mode = sm_i; multiplicand = m_i; multiplier = q_i; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      lat = 0;
      busy_cnt = busy ? 1 : 0;
      while (!done && lat < 40) begin
         @(posedge clk); #1;
         lat++;
         if (busy) busy_cnt++;
      end
      prod = product;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 30) begin
         @(posedge clk); #1;
         n++;
      end
      check_output("wait_idle", 64'(busy), 64'd0);
   endtask

   initial begin
      vec_t vecs[10];
      int lat, bc, exp_lat, dones;
      logic [31:0] prod;

      vecs[0] = '{1'b1, 16'hFFFD, 16'h0005, 32'hFFFFFFF1};
      vecs[1] = '{1'b0, 16'hFFFF, 16'hFFFF, 32'hFFFE0001};
      vecs[2] = '{1'b1, 16'hFFFF, 16'hFFFF, 32'h00000001};
      vecs[3] = '{1'b1, 16'h8000, 16'h8000, 32'h40000000};
      vecs[4] = '{1'b0, 16'h0007, 16'h0006, 32'h0000002A};
      vecs[5] = '{1'b0, 16'h0000, 16'h1234, 32'h00000000};
      vecs[6] = '{1'b1, 16'h7FFF, 16'h8000, 32'hC0008000};
      vecs[7] = '{1'b0, 16'h8000, 16'h8000, 32'h40000000};
      vecs[8] = '{1'b1, 16'h1234, 16'hFFFF, 32'hFFFFEDCC};
      vecs[9] = '{1'b0, 16'h1234, 16'h0010, 32'h00012340};

      #2;
      check_output("reset_busy", 64'(busy), 64'd0);
      check_output("reset_done", 64'(done), 64'd0);
      check_output("reset_product", 64'(product), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      for (int i = 0; i < 10; i++) begin
         exp_lat = 9;
`ifdef BOOTH_ZERO_SKIP_EN
         if (vecs[i].m == 16'h0 || vecs[i].q == 16'h0) exp_lat = 0;
`endif
         apply_stimulus(vecs[i].sm, vecs[i].m, vecs[i].q, lat, bc, prod);
         check_output($sformatf("vec%0d_product", i), 64'(prod), 64'(vecs[i].exp));
         check_output($sformatf("vec%0d_latency", i), 64'(lat), 64'(exp_lat));
         check_output($sformatf("vec%0d_busy_cycles", i), 64'(bc), 64'(exp_lat + 1));
         @(posedge clk); #1;
         check_output($sformatf("vec%0d_done_pulse", i), 64'(done), 64'd0);
      end

      // Product must hold while inputs wiggle without start
      apply_stimulus(1'b1, 16'h8000, 16'h8000, lat, bc, prod);
      dones = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         multiplicand = 16'($urandom); multiplier = 16'($urandom); signed_mode = 1'($urandom);
         @(posedge clk); #1;
         if (done) dones++;
      end
      check_output("hold_product", 64'(product), 64'h40000000);
      check_output("hold_no_done", 64'(dones), 64'd0);

      // start pulsed while busy is ignored
      @(negedge clk);
      signed_mode = 1'b0; multiplicand = 16'd7; multiplier = 16'd6; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      multiplicand = 16'd2; multiplier = 16'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check_output("busy_start_dones", 64'(dones), 64'd1);
      check_output("busy_start_product", 64'(product), 64'h2A);

      // start held high: back-to-back operations
      @(negedge clk);
      signed_mode = 1'b0; multiplicand = 16'd7; multiplier = 16'd6; start = 1'b1;
      dones = 0;
      for (int i = 0; i < 23; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      start = 1'b0;
      check_output("b2b_dones", 64'(dones), 64'd2);
      wait_idle();

      // Asynchronous reset mid-CALC aborts without done
      @(negedge clk);
      signed_mode = 1'b0; multiplicand = 16'h1234; multiplier = 16'h0010; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (3) @(posedge clk);
      #3 rst = 1'b0;
      #1;
      check_output("abort_busy", 64'(busy), 64'd0);
      check_output("abort_done", 64'(done), 64'd0);
      check_output("abort_product", 64'(product), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      dones = 0;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk); #1;
         if (done) dones++;
      end
      check_output("abort_no_done", 64'(dones), 64'd0);
      apply_stimulus(1'b0, 16'd3, 16'd3, lat, bc, prod);
      check_output("after_abort_product", 64'(prod), 64'd9);
      check_output("after_abort_latency", 64'(lat), 64'd9);

      // WIDTH=8 sweep against a behavioural multiply
      for (int i = 0; i < 1000; i++) begin
         int n;
         logic [15:0] exp8;
         @(negedge clk);
         sm8 = 1'($urandom); m8 = 8'($urandom); q8 = 8'($urandom); start8 = 1'b1;
         @(posedge clk); #1;
         start8 = 1'b0;
         n = 0;
         while (!done8 && n < 20) begin
            @(posedge clk); #1;
            n++;
         end
         if (sm8) exp8 = 16'(int'($signed(m8)) * int'($signed(q8)));
         else     exp8 = 16'(int'(m8) * int'(q8));
         check_output($sformatf("w8_%0d_%0h_%0h_s%0d", i, m8, q8, sm8), 64'(done8 ? prod8 : ~exp8), 64'(exp8));
         @(posedge clk); #1;
      end

      $display("[TB] %0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
